park_xform_pipe: RTL and testbench

Pipelined, parametrised Park / inverse-Park transform with valid/ready handshake, internal sin/cos table and per-sample mode select. It is the successor to the fixed 16-bit Park block. It sits between the Clarke stage and the current controllers in the forward direction, and between the controllers and the SVPWM sector logic in the inverse direction. A pass-through tag lets several motor channels share one instance, time-multiplexed.

---
 rtl/park_xform_pipe.sv | 197 +++++++++++++++++++
 tb/tb_park_xform_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/park_xform_pipe.sv
// Pipelined Park / inverse-Park rotation with valid/ready handshake and an
// elaboration-time sin/cos table; three register stages under one global stall.
module park_xform_pipe #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 16,
  parameter int unsigned LUT_BITS = 8,
  parameter int unsigned TAG_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_inv,
  input  logic [DW-1:0]    s_x,
  input  logic [DW-1:0]    s_y,
  input  logic [AW-1:0]    s_theta,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_x,
  output logic [DW-1:0]    m_y,
  output logic             m_sat,
  output logic [TAG_W-1:0] m_tag
);

  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned SW    = 2 * DW + 1;
  localparam int unsigned RW    = DW + 2;
  localparam int unsigned LUT_N = 1 << LUT_BITS;
  localparam int unsigned AMP   = (1 << (DW - 1)) - 1;
  localparam real         PI    = 3.14159265358979323846;
  localparam logic signed [SW-1:0] RND = SW'(1) << (DW - 2);

  // Table entry evaluated at elaboration: round(AMP * cos/sin(2*pi*k/LUT_N)).
  function automatic logic signed [DW-1:0] tbl_val(input int unsigned k, input logic is_sin);
    real ang;
    real v;
    ang = 2.0 * PI * real'(k) / real'(LUT_N);
    v   = real'(AMP) * (is_sin ? $sin(ang) : $cos(ang));
    return DW'($rtoi($floor(v + 0.5)));
  endfunction

  // Clamp a rounded result into DW bits; MSB of the return value flags a clamp.
  function automatic logic [DW:0] sat_fn(input logic signed [RW-1:0] v);
    if ((&v[RW-1:DW-1]) || !(|v[RW-1:DW-1])) begin
      return {1'b0, v[DW-1:0]};
    end else if (v[RW-1]) begin
      return {1'b1, 1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(DW-1){1'b1}}};
    end
  endfunction

  logic signed [DW-1:0] cos_tbl [LUT_N];
  logic signed [DW-1:0] sin_tbl [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_tbl
    localparam logic signed [DW-1:0] COS_K = tbl_val(k, 1'b0);
    localparam logic signed [DW-1:0] SIN_K = tbl_val(k, 1'b1);
    assign cos_tbl[k] = COS_K;
    assign sin_tbl[k] = SIN_K;
  end

  // Angle bits below the table resolution are truncated away.
  if (AW > LUT_BITS) begin : g_theta_lsb
    logic unused_theta_lsb;
    assign unused_theta_lsb = ^s_theta[AW-LUT_BITS-1:0];
  end

  logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DW-1:0]    x1_q, x1_d, y1_q, y1_d, c1_q, c1_d, sn1_q, sn1_d;
  logic                    inv1_q, inv1_d, inv2_q, inv2_d;
  logic [TAG_W-1:0]        tag1_q, tag1_d, tag2_q, tag2_d;
  logic signed [PW-1:0]    pxc2_q, pxc2_d, pys2_q, pys2_d, pxs2_q, pxs2_d, pyc2_q, pyc2_d;
  logic [DW-1:0]           m_x_q, m_x_d, m_y_q, m_y_d;
  logic                    m_sat_q, m_sat_d;
  logic [TAG_W-1:0]        m_tag_q, m_tag_d;

  logic                    en_c;
  logic [LUT_BITS-1:0]     idx_c;
  logic signed [SW-1:0]    sum_x_c, sum_y_c;
  logic signed [RW-1:0]    sh_x_c, sh_y_c;
  logic [DW:0]             sat_x_c, sat_y_c;

  // Next-state for all three stages; nothing moves while the output is stalled.
  always_comb begin
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    c1_d    = c1_q;
    sn1_d   = sn1_q;
    inv1_d  = inv1_q;
    tag1_d  = tag1_q;
    pxc2_d  = pxc2_q;
    pys2_d  = pys2_q;
    pxs2_d  = pxs2_q;
    pyc2_d  = pyc2_q;
    inv2_d  = inv2_q;
    tag2_d  = tag2_q;
    m_x_d   = m_x_q;
    m_y_d   = m_y_q;
    m_sat_d = m_sat_q;
    m_tag_d = m_tag_q;

    en_c  = !v3_q || m_ready;
    idx_c = s_theta[AW-1 -: LUT_BITS];

    sum_x_c = inv2_q ? (SW'(pxc2_q) - SW'(pys2_q)) : (SW'(pxc2_q) + SW'(pys2_q));
    sum_y_c = inv2_q ? (SW'(pxs2_q) + SW'(pyc2_q)) : (SW'(pyc2_q) - SW'(pxs2_q));
    sh_x_c  = RW'((sum_x_c + RND) >>> (DW - 1));
    sh_y_c  = RW'((sum_y_c + RND) >>> (DW - 1));
    sat_x_c = sat_fn(sh_x_c);
    sat_y_c = sat_fn(sh_y_c);

    if (en_c) begin
      v1_d = s_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      if (s_valid) begin
        x1_d   = s_x;
        y1_d   = s_y;
        c1_d   = cos_tbl[idx_c];
        sn1_d  = sin_tbl[idx_c];
        inv1_d = s_inv;
        tag1_d = s_tag;
      end
      if (v1_q) begin
        pxc2_d = PW'(x1_q) * PW'(c1_q);
        pys2_d = PW'(y1_q) * PW'(sn1_q);
        pxs2_d = PW'(x1_q) * PW'(sn1_q);
        pyc2_d = PW'(y1_q) * PW'(c1_q);
        inv2_d = inv1_q;
        tag2_d = tag1_q;
      end
      if (v2_q) begin
        m_x_d   = sat_x_c[DW-1:0];
        m_y_d   = sat_y_c[DW-1:0];
        m_sat_d = sat_x_c[DW] | sat_y_c[DW];
        m_tag_d = tag2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      c1_q    <= '0;
      sn1_q   <= '0;
      inv1_q  <= 1'b0;
      tag1_q  <= '0;
      pxc2_q  <= '0;
      pys2_q  <= '0;
      pxs2_q  <= '0;
      pyc2_q  <= '0;
      inv2_q  <= 1'b0;
      tag2_q  <= '0;
      m_x_q   <= '0;
      m_y_q   <= '0;
      m_sat_q <= 1'b0;
      m_tag_q <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      c1_q    <= c1_d;
      sn1_q   <= sn1_d;
      inv1_q  <= inv1_d;
      tag1_q  <= tag1_d;
      pxc2_q  <= pxc2_d;
      pys2_q  <= pys2_d;
      pxs2_q  <= pxs2_d;
      pyc2_q  <= pyc2_d;
      inv2_q  <= inv2_d;
      tag2_q  <= tag2_d;
      m_x_q   <= m_x_d;
      m_y_q   <= m_y_d;
      m_sat_q <= m_sat_d;
      m_tag_q <= m_tag_d;
    end
  end

  assign s_ready = en_c;
  assign m_valid = v3_q;
  assign m_x     = m_x_q;
  assign m_y     = m_y_q;
  assign m_sat   = m_sat_q;
  assign m_tag   = m_tag_q;

endmodule

// File: tb/tb_park_xform_pipe.sv
// Scoreboard bench for park_xform_pipe: directed spec points plus randomized
// traffic under random backpressure, checked against a real-arithmetic model.
module tb_park_xform_pipe;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_inv = 1'b0;
  logic [DW-1:0] s_x = '0;
  logic [DW-1:0] s_y = '0;
  logic [AW-1:0] s_theta = '0;
  logic [TW-1:0] s_tag = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_x;
  logic [DW-1:0] m_y;
  logic          m_sat;
  logic [TW-1:0] m_tag;

  typedef struct {
    int x;
    int y;
    bit sat;
    int tag;
    int acc;
    bit lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   bp_mode = 0;

  park_xform_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_inv(s_inv),
    .s_x(s_x), .s_y(s_y), .s_theta(s_theta), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_x(m_x), .m_y(m_y), .m_sat(m_sat), .m_tag(m_tag)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output-ready driver: 0 = always ready, 1 = random, 2 = never ready.
  initial forever begin
    @(negedge clk);
    case (bp_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  function automatic int tbl(int k, bit is_sin);
    real a;
    real v;
    a = 2.0 * 3.14159265358979323846 * real'(k) / 256.0;
    v = 32767.0 * (is_sin ? $sin(a) : $cos(a));
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int round_sat(input real v, output bit s);
    real r;
    r = $floor((v + 16384.0) / 32768.0);
    s = 1'b0;
    if (r > 32767.0) begin s = 1'b1; return 32767; end
    if (r < -32768.0) begin s = 1'b1; return -32768; end
    return $rtoi(r);
  endfunction

  function automatic exp_t model(bit inv, int x, int y, int th, int tag);
    exp_t e;
    real  c, s, rx, ry, xr, yr;
    bit   sx, sy;
    c  = real'(tbl(th / 256, 1'b0));
    s  = real'(tbl(th / 256, 1'b1));
    xr = real'(x);
    yr = real'(y);
    if (inv) begin
      rx = xr * c - yr * s;
      ry = xr * s + yr * c;
    end else begin
      rx = xr * c + yr * s;
      ry = yr * c - xr * s;
    end
    e.x   = round_sat(rx, sx);
    e.y   = round_sat(ry, sy);
    e.sat = sx | sy;
    e.tag = tag;
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send(input bit inv, input int x, input int y, input int th, input int tag,
                      input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_inv   = inv;
    s_x     = DW'(x);
    s_y     = DW'(y);
    s_theta = AW'(th);
    s_tag   = TW'(tag);
    #2;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (!s_ready) begin
      failures++;
      $display("FAIL accept_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
    end else begin
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic dir(input bit inv, input int x, input int y, input int th, input int tag,
                     input int ex, input int ey, input bit esat);
    exp_t e;
    e.x = ex; e.y = ey; e.sat = esat; e.tag = tag; e.acc = 0; e.lat = 1'b1;
    send(inv, x, y, th, tag, e);
  endtask

  task automatic send_rand();
    bit inv;
    int x, y, th, tag;
    inv = 1'($urandom_range(0, 1));
    x   = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 32767 : -32768)
                                      : int'($urandom_range(0, 65535)) - 32768;
    y   = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 32767 : -32768)
                                      : int'($urandom_range(0, 65535)) - 32768;
    th  = ($urandom_range(0, 9) == 0) ? 65535 : int'($urandom_range(0, 65535));
    tag = int'($urandom_range(0, 3));
    send(inv, x, y, th, tag, model(inv, x, y, th, tag));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: handshake invariant, hold-while-stalled, and in-order scoreboard pops.
  initial begin
    bit            stall_prev;
    logic [DW-1:0] px, py;
    logic          ps;
    logic [TW-1:0] pt;
    exp_t          e;
    stall_prev = 1'b0;
    px = '0; py = '0; ps = 1'b0; pt = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall_prev = 1'b0;
        continue;
      end
      checks++;
      if (s_ready !== (!m_valid || m_ready)) begin
        failures++;
        $display("FAIL s_ready_rule: s_ready=%0b, required %0b", s_ready, (!m_valid || m_ready));
      end
      if (stall_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_x !== px || m_y !== py || m_sat !== ps || m_tag !== pt) begin
          failures++;
          $display("FAIL stall_hold: got v=%0b x=%0d y=%0d, required v=1 x=%0d y=%0d",
                   m_valid, $signed(m_x), $signed(m_y), $signed(px), $signed(py));
        end
      end
      if (m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_valid: m_valid=1 with %0d samples outstanding, required 0", 0);
        end else if (m_ready) begin
          e = exp_q.pop_front();
          if (int'($signed(m_x)) != e.x || int'($signed(m_y)) != e.y || m_sat != e.sat ||
              int'(m_tag) != e.tag) begin
            failures++;
            $display("FAIL out_data: got x=%0d y=%0d sat=%0b tag=%0d, required x=%0d y=%0d sat=%0b tag=%0d",
                     $signed(m_x), $signed(m_y), m_sat, m_tag, e.x, e.y, e.sat, e.tag);
          end
          if (e.lat) chk("latency_edges", cyc - e.acc, 2);
        end
      end
      stall_prev = m_valid && !m_ready;
      px = m_x; py = m_y; ps = m_sat; pt = m_tag;
    end
  end

  initial begin
    // Reset held with a valid sample presented: nothing may enter or appear.
    s_valid = 1'b1; s_x = 16'd1234; s_y = 16'd77; s_theta = 16'h1234; s_tag = 2'd3;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_x", int'(m_x), 0);
    chk("rst_m_y", int'(m_y), 0);
    chk("rst_m_sat", int'(m_sat), 0);
    chk("rst_m_tag", int'(m_tag), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #2;
      chk("idle_after_reset", int'(m_valid), 0);
    end

    // Directed points, m_ready held high so latency is exact.
    bp_mode = 0;
    dir(1'b0,  32767,     0, 16'h0000, 0,  32766,      0, 1'b0);
    dir(1'b0,  32767, 32767, 16'h0000, 1,  32766,  32766, 1'b0);
    dir(1'b0, -32768,     0, 16'h0000, 3, -32767,      0, 1'b0);
    dir(1'b0,  32767,     0, 16'h4000, 0,      0, -32766, 1'b0);
    dir(1'b0,  32767, 32767, 16'h2000, 1,  32767,      0, 1'b1);
    dir(1'b1,  10000,     0, 16'h0000, 2,  10000,      0, 1'b0);
    dir(1'b0,   1000, -2000, 16'h0000, 1,   1000,  -2000, 1'b0);
    drain();

    // Randomized traffic under random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      send_rand();
    end
    bp_mode = 0;
    drain();

    // Fill the pipe against a blocked output, then reset mid-stream.
    bp_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_rand();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_m_x", int'(m_x), 0);
    chk("midrst_s_ready", int'(s_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    bp_mode = 0;
    rst_n   = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("idle_after_midrst", int'(m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
